// File: rtl/ddr3_rw_arbiter.sv
// -----------------------------------------------------------------------------
// ddr3_rw_arbiter
//
// Purpose
//   Moves fixed-length bursts between a pair of user-side FIFOs and a Xilinx
//   MIG DDR3 user interface. Each burst is BL app commands long. A write
//   burst pops the write FIFO (first-word-fall-through), and every accepted
//   beat carries one command together with its single write-data word. A
//   read burst issues BL read commands and then waits until BL read beats
//   have come back. Returned read data is always forwarded to the read FIFO
//   one cycle later, whatever the arbiter state.
//
// Parameters
//   BL        app commands per burst (2..255)
//   DW        data MSB index; the data buses are DW+1 bits wide
//   ADDR_STEP app_addr increment per app command
//
// Ports
//   ui_clk, ui_clk_sync_rst     MIG user clock; synchronous active-high reset
//   init_calib_complete         DDR calibrated; gates leaving IDLE
//   wr_data_req / rd_data_req   burst requests from the write / read FIFO side
//   wr_cmd_rden / wr_cmd_rdaddr write burst base address and its advance pulse
//   rd_cmd_rden / rd_cmd_rdaddr read burst base address and its advance pulse
//   wr_fifo_rden / wr_fifo_rdata  write FIFO pop and its FWFT data
//   rd_fifo_wren / rd_fifo_wdata  read FIFO push and its data
//   app_en/app_cmd/app_addr/app_rdy                    MIG command channel
//   app_wdf_wren/app_wdf_end/app_wdf_data/app_wdf_mask/app_wdf_rdy
//                                                      MIG write-data channel
//   app_rd_data / app_rd_data_valid                    MIG read-data channel
//   busy                        arbiter is anywhere other than IDLE
//
// Build option
//   ARB_ROUND_ROBIN_EN  When defined, simultaneous requests alternate
//                       between write and read; the first grant after reset
//                       goes to write. When undefined, writes always win.
// -----------------------------------------------------------------------------
module ddr3_rw_arbiter #(
    parameter int BL        = 64,
    parameter int DW        = 255,
    parameter int ADDR_STEP = 8
) (
    input  logic                  ui_clk,
    input  logic                  ui_clk_sync_rst,
    input  logic                  init_calib_complete,
    input  logic                  wr_data_req,
    input  logic                  rd_data_req,
    output logic                  wr_cmd_rden,
    input  logic [27:0]           wr_cmd_rdaddr,
    output logic                  rd_cmd_rden,
    input  logic [27:0]           rd_cmd_rdaddr,
    output logic                  wr_fifo_rden,
    input  logic [DW:0]           wr_fifo_rdata,
    output logic                  rd_fifo_wren,
    output logic [DW:0]           rd_fifo_wdata,
    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [27:0]           app_addr,
    input  logic                  app_rdy,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [DW:0]           app_wdf_data,
    output logic [(DW+1)/8-1:0]   app_wdf_mask,
    input  logic                  app_wdf_rdy,
    input  logic [DW:0]           app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  busy
);

    // Counter wide enough to hold the value BL itself (the read-return
    // counter has to reach BL before RD_WAIT can be left).
    localparam int          CW       = $clog2(BL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BL - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BL);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [27:0] STEP     = 28'(ADDR_STEP);

    localparam logic [2:0]  CMD_WRITE = 3'b000;
    localparam logic [2:0]  CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_WR      = 3'd2,
        S_RD      = 3'd3,
        S_RD_WAIT = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [27:0]     r_addr;        // address of the command being presented
    logic [CW-1:0]   r_cmd_cnt;     // commands (WR: beats) accepted this burst
    logic [CW-1:0]   r_beat_cnt;    // read beats returned this burst
    logic            r_rd_wren;
    logic [DW:0]     r_rd_wdata;

    logic            w_grant_wr;
    logic            w_grant_rd;
    logic            w_wr_fire;     // write beat accepted by both MIG channels
    logic            w_rd_fire;     // read command accepted
    logic            w_beats_done;  // last read beat has arrived (or is arriving)

`ifdef ARB_ROUND_ROBIN_EN
    // Set after a write grant, cleared after a read grant: tells the next
    // contested arbitration to favour reads.
    logic            r_prio_rd;
`endif

    // -------------------------------------------------------------------------
    // Grant selection. Only meaningful while in ARB; the FSM qualifies it.
    // -------------------------------------------------------------------------
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (wr_data_req && rd_data_req) begin
            w_grant_wr = !r_prio_rd;
            w_grant_rd =  r_prio_rd;
        end else begin
            w_grant_wr = wr_data_req;
            w_grant_rd = rd_data_req;
        end
`else
        w_grant_wr = wr_data_req;
        w_grant_rd = rd_data_req && !wr_data_req;
`endif
    end

    assign w_wr_fire = (r_state == S_WR) && app_rdy && app_wdf_rdy;
    assign w_rd_fire = (r_state == S_RD) && app_rdy;

    // A beat that arrives in the cycle that completes the count also ends
    // the wait, so RD_WAIT is not held one extra cycle.
    assign w_beats_done = (r_beat_cnt == CNT_FULL) ||
                          (app_rd_data_valid && (r_beat_cnt == CNT_LAST));

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and strobes
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        app_en       = 1'b0;
        app_cmd      = CMD_WRITE;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        wr_fifo_rden = 1'b0;
        wr_cmd_rden  = 1'b0;
        rd_cmd_rden  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (init_calib_complete) begin
                    w_state_next = S_ARB;
                end
            end

            S_ARB: begin
                // Never start a burst towards an uncalibrated memory.
                if (!init_calib_complete) begin
                    w_state_next = S_IDLE;
                end else if (w_grant_wr) begin
                    wr_cmd_rden  = 1'b1;
                    w_state_next = S_WR;
                end else if (w_grant_rd) begin
                    rd_cmd_rden  = 1'b1;
                    w_state_next = S_RD;
                end
            end

            S_WR: begin
                // Command and its single data word travel together; every
                // output holds until both MIG channels are ready.
                app_en       = 1'b1;
                app_cmd      = CMD_WRITE;
                app_wdf_wren = 1'b1;
                app_wdf_end  = 1'b1;
                if (w_wr_fire) begin
                    wr_fifo_rden = 1'b1;
                    if (r_cmd_cnt == CNT_LAST) begin
                        w_state_next = S_IDLE;
                    end
                end
            end

            S_RD: begin
                app_en  = 1'b1;
                app_cmd = CMD_READ;
                if (w_rd_fire && (r_cmd_cnt == CNT_LAST)) begin
                    w_state_next = S_RD_WAIT;
                end
            end

            S_RD_WAIT: begin
                if (w_beats_done) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address and burst counters
    // -------------------------------------------------------------------------
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_addr     <= 28'd0;
            r_cmd_cnt  <= '0;
            r_beat_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_prio_rd  <= 1'b0;
`endif
        end else begin
            if (wr_cmd_rden) begin
                r_addr     <= wr_cmd_rdaddr;
                r_cmd_cnt  <= '0;
                r_beat_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                r_prio_rd  <= 1'b1;
`endif
            end else if (rd_cmd_rden) begin
                r_addr     <= rd_cmd_rdaddr;
                r_cmd_cnt  <= '0;
                r_beat_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                r_prio_rd  <= 1'b0;
`endif
            end else begin
                // 28-bit add wraps naturally; there is no carry out.
                if (w_wr_fire || w_rd_fire) begin
                    r_addr    <= r_addr + STEP;
                    r_cmd_cnt <= r_cmd_cnt + CNT_ONE;
                end
                // Read returns may start while commands are still going out.
                if (((r_state == S_RD) || (r_state == S_RD_WAIT)) &&
                    app_rd_data_valid && (r_beat_cnt != CNT_FULL)) begin
                    r_beat_cnt <= r_beat_cnt + CNT_ONE;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read-data forwarding: independent of the FSM so that beats still in
    // flight after an aborted burst reach the read FIFO.
    // -------------------------------------------------------------------------
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_rd_wren  <= 1'b0;
            r_rd_wdata <= '0;
        end else begin
            r_rd_wren  <= app_rd_data_valid;
            r_rd_wdata <= app_rd_data;
        end
    end

    assign rd_fifo_wren  = r_rd_wren;
    assign rd_fifo_wdata = r_rd_wdata;

    // Write FIFO is FWFT, so its head word is already the data for the beat
    // on offer.
    assign app_wdf_data  = wr_fifo_rdata;
    assign app_wdf_mask  = '0;
    assign app_addr      = r_addr;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ddr3_rw_arbiter
//
// Directed bench for ddr3_rw_arbiter with BL=4, DW=31, ADDR_STEP=8. Stimulus
// is driven 1 ns after the rising edge; outputs are sampled a further 1 ns
// later, well before the next rising edge. A small MIG read-return helper
// answers accepted read commands one beat per cycle when enabled.
// -----------------------------------------------------------------------------
module tb_ddr3_rw_arbiter;

    localparam int BL   = 4;
    localparam int DW   = 31;
    localparam int STEP = 8;

    logic                ui_clk = 1'b0;
    logic                ui_clk_sync_rst = 1'b1;
    logic                init_calib_complete = 1'b0;
    logic                wr_data_req = 1'b0;
    logic                rd_data_req = 1'b0;
    logic                wr_cmd_rden;
    logic [27:0]         wr_cmd_rdaddr = 28'd0;
    logic                rd_cmd_rden;
    logic [27:0]         rd_cmd_rdaddr = 28'd0;
    logic                wr_fifo_rden;
    logic [DW:0]         wr_fifo_rdata = '0;
    logic                rd_fifo_wren;
    logic [DW:0]         rd_fifo_wdata;
    logic                app_en;
    logic [2:0]          app_cmd;
    logic [27:0]         app_addr;
    logic                app_rdy = 1'b1;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic [DW:0]         app_wdf_data;
    logic [(DW+1)/8-1:0] app_wdf_mask;
    logic                app_wdf_rdy = 1'b1;
    logic [DW:0]         app_rd_data = '0;
    logic                app_rd_data_valid = 1'b0;
    logic                busy;

    ddr3_rw_arbiter #(
        .BL        (BL),
        .DW        (DW),
        .ADDR_STEP (STEP)
    ) dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .wr_data_req         (wr_data_req),
        .rd_data_req         (rd_data_req),
        .wr_cmd_rden         (wr_cmd_rden),
        .wr_cmd_rdaddr       (wr_cmd_rdaddr),
        .rd_cmd_rden         (rd_cmd_rden),
        .rd_cmd_rdaddr       (rd_cmd_rdaddr),
        .wr_fifo_rden        (wr_fifo_rden),
        .wr_fifo_rdata       (wr_fifo_rdata),
        .rd_fifo_wren        (rd_fifo_wren),
        .rd_fifo_wdata       (rd_fifo_wdata),
        .app_en              (app_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_rdy             (app_rdy),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .busy                (busy)
    );

    always #5 ui_clk = ~ui_clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Per-cycle observations
    logic        s_busy;
    logic        s_wr_cmd;
    logic        s_rd_cmd;
    int          n_pop = 0;
    int          q_grant[$];        // 1 = write grant, 2 = read grant
    logic [63:0] q_wr_addr[$];
    logic [63:0] q_rd_addr[$];
    logic [63:0] q_rd_data[$];

    // MIG read-return helper
    logic        auto_ret = 1'b0;
    int          pend = 0;
    logic [DW:0] ret_seq = 32'hC000_0000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample the current cycle, then advance to 1 ns past the next rising edge.
    task automatic clk_cycle();
        #1;
        s_busy   = busy;
        s_wr_cmd = wr_cmd_rden;
        s_rd_cmd = rd_cmd_rden;
        if (wr_cmd_rden) q_grant.push_back(1);
        if (rd_cmd_rden) q_grant.push_back(2);
        if (wr_fifo_rden) n_pop++;
        if (app_en && app_rdy && app_wdf_rdy && (app_cmd == 3'b000))
            q_wr_addr.push_back(64'(app_addr));
        if (app_en && app_rdy && (app_cmd == 3'b001)) begin
            q_rd_addr.push_back(64'(app_addr));
            pend++;
        end
        if (rd_fifo_wren) q_rd_data.push_back(64'(rd_fifo_wdata));
        @(posedge ui_clk);
        #1;
        if (auto_ret) begin
            if (pend > 0) begin
                app_rd_data_valid = 1'b1;
                app_rd_data       = ret_seq;
                ret_seq           = ret_seq + 1;
                pend--;
            end else begin
                app_rd_data_valid = 1'b0;
            end
        end
    endtask

    // Run until the requested grant pulse is seen; lat = cycles before it.
    task automatic wait_grant(input string tag, input bit is_rd, output int lat);
        bit found;
        found = 1'b0;
        lat   = -1;
        for (int k = 0; k < 40; k++) begin
            clk_cycle();
            if ((is_rd ? s_rd_cmd : s_wr_cmd) == 1'b1) begin
                found = 1'b1;
                lat   = k;
                break;
            end
        end
        check(tag, 64'(found), 64'd1);
        $display("[TB] grant %s seen after %0d cycles", is_rd ? "RD" : "WR", lat);
    endtask

    task automatic wait_idle(input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            clk_cycle();
            if (!s_busy) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 64'(found), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pop0;
        int exp_g[4];
        int g;

        // ---------------- reset state ----------------
        app_rd_data_valid = 1'b1;      // must not reach the read FIFO under reset
        app_rd_data       = 32'h55;
        repeat (3) clk_cycle();
        #1;
        check("rst_busy",     64'(busy),         64'd0);
        check("rst_app_en",   64'(app_en),       64'd0);
        check("rst_addr",     64'(app_addr),     64'd0);
        check("rst_rd_wren",  64'(rd_fifo_wren), 64'd0);
        check("rst_wr_cmd",   64'(wr_cmd_rden),  64'd0);
        check("rst_wdf_wren", 64'(app_wdf_wren), 64'd0);
        app_rd_data_valid = 1'b0;

        // ---------------- single write burst from 0x100 ----------------
        ui_clk_sync_rst     = 1'b0;
        init_calib_complete = 1'b1;
        wr_data_req         = 1'b1;
        wr_cmd_rdaddr       = 28'h100;
        wr_fifo_rdata       = 32'hDEAD_BEEF;
        q_grant.delete();
        q_wr_addr.delete();
        pop0 = n_pop;
        wait_grant("wr1_grant", 1'b0, lat);
        check("wr1_grant_lat", 64'(lat), 64'd1);
        wr_data_req = 1'b0;
        #1;
        check("wr1_app_en",   64'(app_en),       64'd1);
        check("wr1_app_cmd",  64'(app_cmd),      64'd0);
        check("wr1_wdf_end",  64'(app_wdf_end),  64'd1);
        check("wr1_addr0",    64'(app_addr),     64'h100);
        check("wr1_wdf_data", 64'(app_wdf_data), 64'hDEAD_BEEF);
        check("wr1_mask",     64'(app_wdf_mask), 64'd0);
        wait_idle("wr1_idle");
        check("wr1_grants",  64'(q_grant.size()),   64'd1);
        check("wr1_pops",    64'(n_pop - pop0),     64'd4);
        check("wr1_nbeats",  64'(q_wr_addr.size()), 64'd4);
        check("wr1_a0", q_wr_addr[0], 64'h100);
        check("wr1_a1", q_wr_addr[1], 64'h108);
        check("wr1_a2", q_wr_addr[2], 64'h110);
        check("wr1_a3", q_wr_addr[3], 64'h118);
        $display("[TB] write burst @0x100 done");

        // ---------------- write burst with a 3-cycle data stall ----------------
        wr_data_req   = 1'b1;
        wr_cmd_rdaddr = 28'h200;
        q_wr_addr.delete();
        pop0 = n_pop;
        wait_grant("wr2_grant", 1'b0, lat);
        wr_data_req = 1'b0;
        clk_cycle();
        clk_cycle();
        app_wdf_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("wr2_stall_en",   64'(app_en),       64'd1);
            check("wr2_stall_wren", 64'(app_wdf_wren), 64'd1);
            check("wr2_stall_addr", 64'(app_addr),     64'h210);
            check("wr2_stall_pop",  64'(wr_fifo_rden), 64'd0);
            clk_cycle();
        end
        app_wdf_rdy = 1'b1;
        wait_idle("wr2_idle");
        check("wr2_pops", 64'(n_pop - pop0), 64'd4);
        check("wr2_a3",   q_wr_addr[3],      64'h218);
        $display("[TB] stalled write burst @0x200 done");

        // ---------------- read burst from 0x40, returns 10 cycles later ----------------
        rd_data_req   = 1'b1;
        rd_cmd_rdaddr = 28'h40;
        q_rd_addr.delete();
        q_rd_data.delete();
        wait_grant("rd1_grant", 1'b1, lat);
        rd_data_req = 1'b0;
        begin
            logic prev_valid;
            prev_valid = 1'b0;
            for (int t = 0; t < 16; t++) begin
                app_rd_data_valid = (t >= 10) && (t <= 13);
                app_rd_data       = 32'(32'hA0 + t - 10);
                #1;
                if (t >= 9) check("rd1_wren_lat", 64'(rd_fifo_wren), 64'(prev_valid));
                if (t == 13) check("rd1_busy_b4", 64'(busy), 64'd1);
                if (t == 14) check("rd1_busy_end", 64'(busy), 64'd0);
                prev_valid = app_rd_data_valid;
                clk_cycle();
            end
            app_rd_data_valid = 1'b0;
        end
        check("rd1_ncmd", 64'(q_rd_addr.size()), 64'd4);
        check("rd1_a0", q_rd_addr[0], 64'h40);
        check("rd1_a1", q_rd_addr[1], 64'h48);
        check("rd1_a2", q_rd_addr[2], 64'h50);
        check("rd1_a3", q_rd_addr[3], 64'h58);
        check("rd1_nbeat", 64'(q_rd_data.size()), 64'd4);
        check("rd1_d0", q_rd_data[0], 64'hA0);
        check("rd1_d3", q_rd_data[3], 64'hA3);
        $display("[TB] read burst @0x40 done");

        // ---------------- contested arbitration, 4 bursts ----------------
        pend     = 0;
        auto_ret = 1'b1;
        wr_cmd_rdaddr = 28'h300;
        rd_cmd_rdaddr = 28'h80;
        wr_data_req   = 1'b1;
        rd_data_req   = 1'b1;
        q_grant.delete();
        for (int k = 0; k < 400; k++) begin
            clk_cycle();
            if (q_grant.size() >= 4) break;
        end
        wr_data_req = 1'b0;
        rd_data_req = 1'b0;
        wait_idle("arb_idle");
        for (int k = 0; k < 10; k++) clk_cycle();   // let trailing returns drain
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{1, 2, 1, 2};
`else
        exp_g = '{1, 1, 1, 1};
`endif
        check("arb_ngrants", 64'(q_grant.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            g = (k < q_grant.size()) ? q_grant[k] : 0;
            check($sformatf("arb_grant%0d", k), 64'(g), 64'(exp_g[k]));
            $display("[TB] contested burst %0d granted to %s", k, (g == 1) ? "WR" : "RD");
        end

        // ---------------- reset in the middle of a read burst ----------------
        auto_ret          = 1'b0;
        app_rd_data_valid = 1'b0;
        rd_data_req       = 1'b1;
        rd_cmd_rdaddr     = 28'h500;
        wait_grant("rst_rd_grant", 1'b1, lat);
        rd_data_req = 1'b0;
        clk_cycle();
        clk_cycle();
        ui_clk_sync_rst = 1'b1;
        clk_cycle();
        #1;
        check("mid_rst_app_en", 64'(app_en),   64'd0);
        check("mid_rst_busy",   64'(busy),     64'd0);
        check("mid_rst_addr",   64'(app_addr), 64'd0);
        ui_clk_sync_rst   = 1'b0;
        app_rd_data_valid = 1'b1;          // late beat from the aborted burst
        app_rd_data       = 32'h77;
        clk_cycle();
        app_rd_data_valid = 1'b0;
        #1;
        check("late_rd_wren",  64'(rd_fifo_wren),  64'd1);
        check("late_rd_wdata", 64'(rd_fifo_wdata), 64'h77);
        pend        = 0;
        auto_ret    = 1'b1;
        rd_data_req = 1'b1;
        wait_grant("rst_rd_regrant", 1'b1, lat);
        rd_data_req = 1'b0;
        #1;
        check("regrant_addr", 64'(app_addr), 64'h500);
        wait_idle("regrant_idle");
        for (int k = 0; k < 10; k++) clk_cycle();
        auto_ret = 1'b0;
        $display("[TB] reset-aborted read burst and re-grant done");

        // ---------------- address wrap, calibration lost mid-burst ----------------
        wr_cmd_rdaddr = 28'hFFF_FFF8;
        wr_data_req   = 1'b1;
        q_wr_addr.delete();
        wait_grant("wrap_grant", 1'b0, lat);
        wr_data_req         = 1'b0;
        init_calib_complete = 1'b0;
        wait_idle("wrap_idle");
        check("wrap_nbeats", 64'(q_wr_addr.size()), 64'd4);
        check("wrap_a0", q_wr_addr[0], 64'hFFF_FFF8);
        check("wrap_a1", q_wr_addr[1], 64'h000_0000);
        check("wrap_a2", q_wr_addr[2], 64'h000_0008);
        wr_data_req = 1'b1;
        q_grant.delete();
        for (int k = 0; k < 4; k++) begin
            clk_cycle();
            check("uncal_hold_idle", 64'(s_busy), 64'd0);
        end
        check("uncal_no_grant", 64'(q_grant.size()), 64'd0);
        wr_data_req = 1'b0;
        $display("[TB] wrapped write burst @0xFFFFFF8 done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
